// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity-mode encodings,
// frame-format limits and the parity helper.
package uart_pkg;

  // Transmitter frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity-mode encodings carried with every queued byte (2'b11 also means none)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Legal frame-format limits
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  // Unused upper data bits must be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic even_p;
    even_p = ^data;
    return (mode == PAR_ODD) ? ~even_p : even_p;
  endfunction

  // True when the mode asks for a parity bit in the frame
  function automatic logic parity_used(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count. Writes while full and reads while
// empty are ignored. Pointers wrap naturally because DEPTH is a power of 2.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Next pointer and occupancy; a simultaneous push and pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO of bytes feeding a frame sequencer
// (start, data LSB first, optional parity, 1 or 2 stop bits).
// Optional feature macro: UART_TX_PARITY_EN -- when defined, every queued byte
// carries the parity mode sampled with it and frames may include a parity bit;
// when undefined, i_Parity_Mode is ignored and frames never carry parity.
// Handshake: a byte is accepted on a rising edge where i_Tx_DV and o_Tx_Ready
// are both high; o_Tx_Ready is low while the FIFO is full or reset is asserted.
// The serial line, o_Tx_Active and o_Tx_Done are registered and lag the state
// register by one cycle, so o_Tx_Done lands in the cycle after the last stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  input  logic [1:0]                    i_Parity_Mode,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output tx_state_e                     o_Dbg_State
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam int FW = DATA_BITS + 2;
`else
  localparam int FW = DATA_BITS;
`endif

  // FIFO interface
  logic                         fifo_push, fifo_pop;
  logic                         fifo_full, fifo_empty;
  logic [FW-1:0]                fifo_wr_data, fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [DATA_BITS-1:0]         pop_byte;

  // Sequencer state
  tx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_pend_q, done_pend_d;
  logic                 done_q, done_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic [1:0] pop_mode;
  logic       par_bit_q, par_bit_d;
  logic       par_en_q, par_en_d;
  assign fifo_wr_data = {i_Parity_Mode, i_Tx_Byte};
  assign pop_mode     = fifo_rd_data[FW-1 -: 2];
`else
  logic unused_parity_mode;
  assign fifo_wr_data       = i_Tx_Byte;
  assign unused_parity_mode = ^i_Parity_Mode;
`endif

  assign pop_byte   = fifo_rd_data[DATA_BITS-1:0];
  assign o_Tx_Ready = !fifo_full && !i_Reset;
  assign fifo_push  = i_Tx_DV && o_Tx_Ready;
  assign bit_end    = (clk_cnt_q == LAST_TICK);

  uart_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .push      (fifo_push),
    .push_data (fifo_wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Frame sequencer: next state, bit timing, line value and frame loading
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    done_pend_d = 1'b0;
    serial_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_bit_d   = par_bit_q;
    par_en_d    = par_en_q;
`endif
    if (state_q != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        serial_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = par_en_q ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = par_bit_q;
        if (bit_end) begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
      end
`endif
      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            done_pend_d = 1'b1;
            bit_idx_d   = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = START;
            end else begin
              state_d  = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    // A pop always starts a new frame: load its data and parity setup
    if (fifo_pop) begin
      shift_d   = pop_byte;
`ifdef UART_TX_PARITY_EN
      par_bit_d = parity_bit(8'(pop_byte), pop_mode);
      par_en_d  = parity_used(pop_mode);
`endif
    end

    active_d = (state_q != IDLE);
    done_d   = done_pend_q;
  end

  // Sequencer and registered output flops; reset aborts any frame in flight
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      par_bit_q   <= par_bit_d;
      par_en_q    <= par_en_d;
`endif
    end
  end

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = fifo_count;
  assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: two instances (8N1 and 5-bit/2-stop), directed
// writes push expected frames into a queue, a per-instance monitor reassembles
// each frame from the serial line cycle by cycle and checks it.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int C = 4;
  localparam int W = 11;  // {instance id, parity mode, data byte}
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 8 data bits, 1 stop bit
  logic       dv_a = 1'b0;
  logic [7:0] byte_a = '0;
  logic [1:0] mode_a = '0;
  logic       ready_a, serial_a, active_a, done_a;
  logic [2:0] count_a;
  tx_state_e  state_a;

  // Instance B: 5 data bits, 2 stop bits
  logic       dv_b = 1'b0;
  logic [4:0] byte_b = '0;
  logic [1:0] mode_b = '0;
  logic       ready_b, serial_b, active_b, done_b;
  logic [2:0] count_b;
  tx_state_e  state_b;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
    .i_Parity_Mode(mode_a), .o_Tx_Ready(ready_a), .o_Tx_Serial(serial_a),
    .o_Tx_Active(active_a), .o_Tx_Done(done_a), .o_Fifo_Count(count_a),
    .o_Dbg_State(state_a)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
    .i_Parity_Mode(mode_b), .o_Tx_Ready(ready_b), .o_Tx_Serial(serial_b),
    .o_Tx_Active(active_b), .o_Tx_Done(done_b), .o_Fifo_Count(count_b),
    .o_Dbg_State(state_b)
  );

  logic serial_w [2];
  logic active_w [2];
  logic done_w   [2];
  assign serial_w[0] = serial_a;
  assign serial_w[1] = serial_b;
  assign active_w[0] = active_a;
  assign active_w[1] = active_b;
  assign done_w[0]   = done_a;
  assign done_w[1]   = done_b;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int start_log[$];
  int n_checks = 0;
  int n_err = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits
  function automatic void frame_bits(input logic [7:0] d, input logic [1:0] m,
                                     input int nd, input int ns,
                                     output logic [15:0] b, output int nb);
    logic p;
    b  = '1;
    b[0] = 1'b0;
    nb = 1;
    p  = 1'b0;
    for (int i = 0; i < nd; i++) begin
      b[nb] = d[i];
      p = p ^ d[i];
      nb++;
    end
    if (PAR_EN && (m == 2'b01 || m == 2'b10)) begin
      b[nb] = (m == 2'b01) ? ~p : p;
      nb++;
    end
    for (int s = 0; s < ns; s++) begin
      b[nb] = 1'b1;
      nb++;
    end
  endfunction

  // Monitor: on a start bit, pop the expected frame and compare every cycle
  task automatic monitor(input int id, input int nd, input int ns);
    logic [W-1:0] e;
    logic [15:0]  b;
    int nb, bad;
    bit skip, aborted;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (rst || serial_w[id] !== 1'b0) continue;
      if (id == 0) start_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        check($sformatf("unexpected_frame_%0d", id), 32'd1, 32'd0);
        for (int k = 0; k < 200 && serial_w[id] === 1'b0; k++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      frame_bits(e[7:0], e[9:8], nd, ns, b, nb);
      bad = (e[10] == id[0]) ? 0 : 1;
      aborted = 1'b0;
      for (int k = 0; k < nb * C; k++) begin
        if (k > 0) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (serial_w[id] !== b[k / C]) bad++;
        if (active_w[id] !== 1'b1) bad++;
        if (k > 0 && done_w[id] !== 1'b0) bad++;
      end
      if (aborted) begin
        while (rst) @(negedge clk);
        continue;
      end
      check($sformatf("frame_%0d_data_%0h_bad_cycles", id, e[7:0]), bad, 0);
      @(negedge clk);
      if (!rst) begin
        check($sformatf("done_pulse_%0d", id), {31'd0, done_w[id]}, 1);
        skip = 1'b1;
      end
    end
  endtask

  // Driver tasks: called just after a rising edge, return just after the next
  task automatic push_a(input logic [7:0] d, input logic [1:0] m);
    dv_a = 1'b1; byte_a = d; mode_a = m;
    exp_q.push_back({1'b0, m, d});
    @(posedge clk); #1;
    dv_a = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] d, input logic [1:0] m);
    dv_b = 1'b1; byte_b = d; mode_b = m;
    exp_q.push_back({1'b1, m, 3'b000, d});
    @(posedge clk); #1;
    dv_b = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int run;
    run = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && serial_a === 1'b1 && active_a === 1'b0 &&
          serial_b === 1'b1 && active_b === 1'b0) run++;
      else run = 0;
      if (run >= 3) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Directed stimulus
  initial begin
    logic [7:0] burst [5];
    int d0;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h4B; burst[3] = 8'h80; burst[4] = 8'hFE;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_serial", {31'd0, serial_a}, 1);
    check("rst_active", {31'd0, active_a}, 0);
    check("rst_done",   {31'd0, done_a}, 0);
    check("rst_count",  {29'd0, count_a}, 0);
    check("rst_ready_low", {31'd0, ready_a}, 0);
    check("rst_state", {29'd0, state_a}, {29'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready_a}, 1);
    check("ready_b_after_rst", {31'd0, ready_b}, 1);
    fork
      monitor(0, 8, 1);
      monitor(1, 5, 2);
    join_none
    @(posedge clk); #1;

    // Single byte 0xA5, no parity; line falls at the second edge after accept
    push_a(8'hA5, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check("latency_still_idle", {31'd0, serial_a}, 1);
    @(negedge clk);
    check("latency_start_low", {31'd0, serial_a}, 0);
    wait_idle(200);

    // Parity: 0x07 even -> 1, odd -> 0; mode 3 means no parity
    push_a(8'h07, 2'b10);
    wait_idle(200);
    push_a(8'h07, 2'b01);
    wait_idle(200);
    push_a(8'hC3, 2'b11);
    wait_idle(200);

    // Six writes on consecutive cycles: five accepted, then hold a write
    // while full across the cycle where the FIFO pops
    start_log.delete();
    for (int i = 0; i < 5; i++) begin
      dv_a = 1'b1; byte_a = burst[i]; mode_a = 2'b00;
      exp_q.push_back({1'b0, 2'b00, burst[i]});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("full_count", {29'd0, count_a}, 4);
    check("full_ready_low", {31'd0, ready_a}, 0);
    byte_a = 8'hEE;
    repeat (36) @(posedge clk);
    #1;
    @(negedge clk);
    check("full_hold_count", {29'd0, count_a}, 4);
    @(posedge clk); #1;
    dv_a = 1'b0;
    @(negedge clk);
    check("push_pop_full_count", {29'd0, count_a}, 3);
    check("push_pop_full_ready", {31'd0, ready_a}, 1);
    wait_idle(400);
    check("burst_frames", start_log.size(), 5);
    if (start_log.size() == 5) begin
      d0 = 0;
      for (int i = 1; i < 5; i++) if (start_log[i] - start_log[i-1] != 10 * C) d0++;
      check("burst_gaps", d0, 0);
    end

    // Reset during data bit 3 with two bytes queued
    push_a(8'h3C, 2'b00);
    push_a(8'h81, 2'b00);
    push_a(8'h42, 2'b00);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    d0 = done_cnt_a;
    @(negedge clk);
    check("abort_serial", {31'd0, serial_a}, 1);
    check("abort_count",  {29'd0, count_a}, 0);
    check("abort_active", {31'd0, active_a}, 0);
    check("abort_done",   {31'd0, done_a}, 0);
    check("abort_ready_low", {31'd0, ready_a}, 0);
    check("abort_state", {29'd0, state_a}, {29'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_high", {31'd0, ready_a}, 1);
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt_a - d0, 0);
    check("abort_line_idle", {31'd0, serial_a}, 1);
    @(posedge clk); #1;

    // Recovery frame
    push_a(8'h5A, 2'b00);
    wait_idle(200);

    // Five data bits, two stop bits
    push_b(5'h1F, 2'b00);
    wait_idle(200);
    push_b(5'h0A, 2'b10);
    wait_idle(200);

    // Totals
    check("done_total_a", done_cnt_a, 10);
    check("done_total_b", done_cnt_b, 2);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
